uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised successor to the fixed 8-bit UART receiver.
- Serial-to-parallel receiver with:
  - runtime-programmable oversampling ratio
  - compile-time data width
  - optional even/odd parity and one or two stop bits
  - 3-sample majority voting
  - separate parity and stop (framing) error pulses
- Sits between the async RX pin and the byte-level consumer, in the same clock domain as the consumer.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal range 5..9.
- PRESCALE_W, 6, width of PRESCALE input; max ratio 2^PRESCALE_W-2.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- RX_IN  input  1  asynchronous serial line; idles high.
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- STOP2  input  1  1 = two stop bits expected.
- PRESCALE  input  PRESCALE_W  CLK cycles per bit (oversampling ratio).
- P_DATA  output  DATA_WIDTH  last good received word.
- data_valid  output  1  one-cycle pulse when P_DATA updates.
- par_err  output  1  one-cycle pulse on parity mismatch.
- stp_err  output  1  one-cycle pulse on a stop bit sampled low.

Behaviour:
- Reset: state IDLE, all counters 0.
  - Outputs on reset: P_DATA=0, data_valid=0, par_err=0, stp_err=0.
  - Synchronizer flops reset to 1.
  - A reset mid-frame aborts the frame with no pulses.
- Input path: RX_IN passes through a 2-flop synchronizer; rxs denotes its output. All timing below refers to rxs.
- Config latch: PAR_EN, PAR_TYP, STOP2 and PRESCALE are captured on the start-detect cycle. Changes mid-frame are ignored until the next frame.
- PRESCALE sanitising: LSB is ignored (forced even). Values below 8 are treated as 8. Call the effective value P.
- Frame timing:
  - t0 = first cycle rxs=0 while in IDLE. The edge counter is 0 at t0.
  - Bit k (start bit is k=0) occupies cycles t0+k*P .. t0+(k+1)*P-1.
  - Edge counter wraps from P-1 to 0 and increments the bit counter.
- Sampling: rxs is sampled at edge counts P/2-1, P/2 and P/2+1. The bit value is the majority of the 3 samples and is decided at edge P/2+1.
- States:
  - IDLE -> START on rxs=0.
  - START:
    - voted 0 -> DATA at bit end.
    - voted 1 (glitch) -> IDLE immediately; no pulses.
  - DATA:
    - DATA_WIDTH bits, LSB first, shifted into an internal register.
    - After the last bit -> PARITY if PAR_EN, else STOP.
  - PARITY:
    - Parity error = XOR(data bits, parity bit) != PAR_TYP.
    - The result is held as a flag; nothing is pulsed yet. Then -> STOP.
  - STOP:
    - One or two bits per STOP2. Each must vote 1.
    - Evaluation happens at the vote of the last stop bit, or at the first stop bit that votes 0.
    - On evaluation: register the outputs in the next cycle, then return to IDLE. No wait for the bit end, which permits early resync.
- Output rules on evaluation:
  - Stop error: stp_err=1. data_valid=0, par_err=0, P_DATA unchanged.
  - Else parity error: par_err=1. data_valid=0, P_DATA unchanged.
  - Else: data_valid=1 and P_DATA=shift register, in the same cycle.
  - All pulses last exactly one cycle. The error outputs are mutually exclusive with data_valid.
- Latency: pulses assert at cycle t0+(N-1)*P+P/2+2, where N = total bits in the frame (including start and stop).
  - Example: P=8, DATA_WIDTH=8, parity on, 1 stop gives N=11, so pulses at t0+86.
- Break handling: after stp_err the FSM enters IDLE but arms start detection only after rxs has been seen high for at least 1 cycle. A held-low line yields exactly one stp_err.
- Back-to-back frames: a start edge arriving at any cycle after the outputs pulse is accepted. No dead cycles beyond the synchronizer are allowed.

Test Plan:
- P=8, DATA_WIDTH=8, PAR_EN=1, PAR_TYP=0, STOP2=0; send start, data 1,0,1,0,1,0,1,0 (LSB first), parity 0, stop 1 -> data_valid high for 1 cycle at t0+86, P_DATA=0x55, par_err=stp_err=0.
- Same frame with parity bit 1 -> par_err pulse at t0+86; data_valid=0; P_DATA keeps the previous value (0 after reset, 0x55 after the first test).
- Same frame with stop bit 0 and line held low for 40 cycles -> exactly one stp_err; no new frame until rxs returns high; the next good frame 0xA3 gives P_DATA=0xA3.
- P=16; RX_IN low for 3 cycles then high -> START vote 1; FSM back to IDLE; no pulses for 200 cycles.
- DATA_WIDTH=7, P=16, PAR_TYP=1, STOP2=1; data 0x41 with odd parity bit 1 and two stop bits -> data_valid at t0+10*16+10, P_DATA=0x41. A second stop bit of 0 instead -> stp_err.
- Two back-to-back 0x55/0xC3 frames (P=8), plus RST asserted mid-DATA of a third frame -> two data_valid pulses with the correct data. After reset all outputs are 0 and no pulse fires for the aborted frame. A subsequent frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// ----------------------------------------------------------------------------
// uart_rx_param
// Parametrised UART receiver. Oversampling ratio is set at runtime, data width
// at compile time. Each bit is decided by a 3-sample majority vote around its
// centre. Frames may carry even/odd parity and one or two stop bits. Parity and
// framing problems are reported as separate one-cycle pulses.
//
// Ports:
//   CLK        system clock
//   RST        synchronous reset, active-high
//   RX_IN      asynchronous serial line, idles high
//   PAR_EN     1 = frame carries a parity bit
//   PAR_TYP    0 = even parity, 1 = odd parity
//   STOP2      1 = two stop bits expected
//   PRESCALE   CLK cycles per bit (LSB ignored, minimum 8)
//   P_DATA     last good received word
//   data_valid one-cycle pulse when P_DATA updates
//   par_err    one-cycle pulse on parity mismatch
//   stp_err    one-cycle pulse on a stop bit sampled low
// PAR_EN, PAR_TYP, STOP2 and PRESCALE are captured when a start edge is seen
// and held for the whole frame.
// ----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  STOP2,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] ONE   = PRESCALE_W'(1);

    state_e                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [PRESCALE_W-1:0]   cnt_q, cnt_d;
    logic [3:0]              bit_q, bit_d;
    logic [1:0]              samp_q, samp_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [PRESCALE_W-1:0]   p_q, p_d;
    logic                    par_en_q, par_en_d;
    logic                    par_typ_q, par_typ_d;
    logic                    stop2_q, stop2_d;
    logic                    perr_q, perr_d;
    logic                    armed_q, armed_d;
    logic [DATA_WIDTH-1:0]   pdata_q, pdata_d;
    logic                    dv_q, dv_d;
    logic                    pe_q, pe_d;
    logic                    se_q, se_d;

    logic                    rxs;
    logic [PRESCALE_W-1:0]   p_even, p_sane, half;
    logic                    at_s0, at_s1, at_vote, at_end;
    logic                    vote, last_stop, eval;

    assign rxs = sync2_q;

    // Prescale sanitising: force even, clamp to the minimum ratio.
    assign p_even = PRESCALE & ~ONE;
    assign p_sane = (p_even < P_MIN) ? P_MIN : p_even;

    assign half    = p_q >> 1;
    assign at_s0   = (cnt_q == half - ONE);
    assign at_s1   = (cnt_q == half);
    assign at_vote = (cnt_q == half + ONE);
    assign at_end  = (cnt_q == p_q - ONE);

    // Third sample is the live synchronised value at the vote edge.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    assign last_stop = (bit_q == (stop2_q ? 4'd1 : 4'd0));

    // Frame is judged at the last stop vote, or earlier at any stop voted low.
    assign eval = (state_q == S_STOP) && at_vote && (!vote || last_stop);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            p_q       <= P_MIN;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            perr_q    <= 1'b0;
            armed_q   <= 1'b1;
            pdata_q   <= '0;
            dv_q      <= 1'b0;
            pe_q      <= 1'b0;
            se_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= RX_IN;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            p_q       <= p_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            stop2_q   <= stop2_d;
            perr_q    <= perr_d;
            armed_q   <= armed_d;
            pdata_q   <= pdata_d;
            dv_q      <= dv_d;
            pe_q      <= pe_d;
            se_q      <= se_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        p_d       = p_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        stop2_d   = stop2_q;
        perr_d    = perr_q;
        armed_d   = armed_q;

        if (state_q != S_IDLE) begin
            cnt_d = at_end ? '0 : cnt_q + ONE;
            if (at_s0) samp_d[0] = rxs;
            if (at_s1) samp_d[1] = rxs;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                // After a break the line must be seen high before re-arming.
                if (rxs) armed_d = 1'b1;
                if (armed_q && !rxs) begin
                    state_d   = S_START;
                    cnt_d     = ONE;     // the detect cycle itself is edge 0
                    p_d       = p_sane;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    stop2_d   = STOP2;
                    perr_d    = 1'b0;
                end
            end
            S_START: begin
                if (at_vote && vote) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (at_vote) shift_d = {vote, shift_q[DATA_WIDTH-1:1]};
                if (at_end) begin
                    if (bit_q == 4'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_vote) perr_d = ((^shift_q) ^ vote) != par_typ_q;
                if (at_end) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (eval) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    if (!vote) armed_d = 1'b0;
                end else if (at_end) begin
                    bit_d = bit_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: registered one cycle after evaluation
    // ------------------------------------------------------------------------
    always_comb begin
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;
        pdata_d = pdata_q;
        if (eval) begin
            if (!vote) begin
                se_d = 1'b1;
            end else if (perr_q) begin
                pe_d = 1'b1;
            end else begin
                dv_d    = 1'b1;
                pdata_d = shift_q;
            end
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = pe_q;
    assign stp_err    = se_q;

endmodule
